skidbuffer: RTL and testbench
=============================

SKIDBUFFER -- requirements
Module: skidbuffer

Interface
REQ-001 SHALL have parameter DW, default 16: data width in bits, legal range 1..1024.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all registers update on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port input_tvalid, input, 1 bit: upstream data valid.
REQ-005 SHALL have port input_tready, output, 1 bit: buffer can accept data.
REQ-006 SHALL have port input_tdata, input, DW bits: upstream data.
REQ-007 SHALL have port output_tvalid, output, 1 bit: downstream data valid.
REQ-008 SHALL have port output_tready, input, 1 bit: downstream can accept data.
REQ-009 SHALL have port output_tdata, output, DW bits: downstream data.

Function
REQ-010 SHALL implement a two-entry registered AXI-Stream skid buffer: an output register (OUT) drives output_tdata, plus one skid register (SKID).
REQ-011 SHALL treat an input transfer as input_tvalid & input_tready, and an output transfer as output_tvalid & output_tready, both sampled on the rising clock edge.
REQ-012 SHALL have three states: EMPTY (OUT and SKID invalid), BUSY (OUT valid, SKID invalid), FULL (OUT and SKID valid).
REQ-013 SHALL drive output_tvalid = 1 in BUSY and FULL, else 0; output_tdata = OUT contents.
REQ-014 SHALL drive input_tready = reset_n & (state != FULL); input_tready is a function of registered state only, with no combinational path from output_tready.
REQ-015 In EMPTY, an input transfer SHALL load OUT and move to BUSY.
REQ-016 In BUSY, simultaneous input and output transfers SHALL load OUT from input_tdata and stay in BUSY.
REQ-017 In BUSY, an input transfer without an output transfer SHALL load SKID and move to FULL.
REQ-018 In BUSY, an output transfer without an input transfer SHALL move to EMPTY.
REQ-019 In FULL, an output transfer SHALL copy SKID into OUT and move to BUSY; with no output transfer, the buffer SHALL hold.
REQ-020 SHALL have 1-cycle latency: a beat accepted at edge N appears on output_tvalid/output_tdata after edge N if OUT is free.
REQ-021 SHALL preserve order, never drop or duplicate beats, and sustain 1 beat/cycle while output_tready stays high.
REQ-022 SHALL keep output_tdata stable while output_tvalid = 1 and output_tready = 0.
REQ-023 SHALL ignore input_tdata whenever input_tready = 0.

Reset
REQ-024 reset_n low SHALL asynchronously force EMPTY: output_tvalid = 0 and input_tready = 0.
REQ-025 The first rising edge with reset_n high SHALL see input_tready = 1, so a beat can be accepted at that edge.
REQ-026 Reset asserted mid-operation SHALL discard OUT and SKID contents with no partial transfer.
REQ-027 Data register values after reset SHALL be set by REQ-028/029.

Configuration
REQ-028 With macro SKIDBUFFER_DATA_CLEAR_EN defined, OUT and SKID data SHALL reset to 0, and OUT SHALL be cleared to 0 on entry to EMPTY, so output_tdata = 0 whenever output_tvalid = 0.
REQ-029 Without SKIDBUFFER_DATA_CLEAR_EN, data registers SHALL have no reset and are not cleared; output_tdata is don't-care while output_tvalid = 0. Handshake behaviour SHALL be identical in both builds.

Verification (DW = 8)
REQ-030 Reset: hold reset_n = 0 -> output_tvalid = 0, input_tready = 0; release -> input_tready = 1; with macro, output_tdata = 0x00.
REQ-031 Streaming: send 0x01..0x10 back-to-back with output_tready = 1 -> 16 beats out in order, one per cycle, each 1 cycle after acceptance, input_tready constantly 1.
REQ-032 Stall: send 0xA1, 0xA2, 0xA3 with output_tready = 0 -> 0xA1, 0xA2 accepted, then input_tready = 0 and 0xA3 held; output_tdata = 0xA1 stable. Raise output_tready -> 0xA1, 0xA2, 0xA3 delivered in order.
REQ-033 FULL plus simultaneous: in FULL, assert output_tready for 1 cycle -> OUT becomes SKID value and input_tready returns to 1 next cycle. In BUSY with both transfers -> stays BUSY with the new beat.
REQ-034 Random: random input_tvalid/output_tready at 50% for 10000 cycles -> scoreboard shows no loss, duplication or reordering, and every stall satisfies REQ-022.
REQ-035 Mid-stream reset: assert reset_n = 0 while in FULL -> output_tvalid drops immediately without waiting for a clock edge; after release, no stale beat is ever output.

Source files
------------

// File: rtl/skidbuffer.sv
// Two-entry registered AXI-Stream skid buffer.
// OUT drives the downstream data; SKID catches the one beat that arrives
// while OUT is stalled. input_tready depends only on registered state.
// Optional build macro: SKIDBUFFER_DATA_CLEAR_EN -- when defined, the data
// registers reset to zero and OUT is zeroed whenever the buffer drains, so
// output_tdata reads 0 while output_tvalid is low.
module skidbuffer #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          input_tvalid,
  output logic          input_tready,
  input  logic [DW-1:0] input_tdata,
  output logic          output_tvalid,
  input  logic          output_tready,
  output logic [DW-1:0] output_tdata
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_out_data;
  logic [DW-1:0] r_skid_data;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_out_in;
  logic w_load_out_skid;
  logic w_load_skid;

  // Handshake outputs decoded from registered state; reset_n gates ready
  // so nothing is accepted while reset is held.
  assign input_tready  = reset_n & (r_state != ST_FULL);
  assign output_tvalid = (r_state != ST_EMPTY);
  assign output_tdata  = r_out_data;

  assign w_in_xfer  = input_tvalid & input_tready;
  assign w_out_xfer = output_tvalid & output_tready;

  // OUT takes the new beat when it is empty or is being emptied this cycle.
  assign w_load_out_in   = w_in_xfer & ((r_state == ST_EMPTY) |
                                        ((r_state == ST_BUSY) & w_out_xfer));
  // SKID catches the beat when OUT is occupied and stalled.
  assign w_load_skid     = w_in_xfer & (r_state == ST_BUSY) & ~w_out_xfer;
  // Draining from FULL promotes the skid beat into OUT.
  assign w_load_out_skid = (r_state == ST_FULL) & w_out_xfer;

  // Occupancy state machine; reset drops straight to EMPTY without a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) r_state <= ST_BUSY;
        ST_BUSY: begin
          if (w_in_xfer && !w_out_xfer)      r_state <= ST_FULL;
          else if (!w_in_xfer && w_out_xfer) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_out_xfer) r_state <= ST_BUSY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef SKIDBUFFER_DATA_CLEAR_EN
  logic w_clear_out;

  // The last beat leaving with nothing behind it empties the buffer.
  assign w_clear_out = (r_state == ST_BUSY) & w_out_xfer & ~w_in_xfer;

  // Data path with reset and zero-on-drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_out_in)        r_out_data <= input_tdata;
      else if (w_load_out_skid) r_out_data <= r_skid_data;
      else if (w_clear_out)     r_out_data <= '0;
      if (w_load_skid)          r_skid_data <= input_tdata;
    end
  end
`else
  // Data path without reset; contents are meaningless while output_tvalid is low.
  always_ff @(posedge clock) begin
    if (w_load_out_in)        r_out_data <= input_tdata;
    else if (w_load_out_skid) r_out_data <= r_skid_data;
    if (w_load_skid)          r_skid_data <= input_tdata;
  end
`endif

endmodule

// File: tb/tb_skidbuffer.sv
// Bench for skidbuffer (DW = 8). The reference is a two-slot FIFO held in a
// queue: the buffer is valid when the queue is non-empty, ready while it
// holds fewer than two beats, and always presents the oldest beat.
module tb_skidbuffer;

  localparam int DW = 8;

  logic          clock;
  logic          reset_n;
  logic          input_tvalid;
  logic          input_tready;
  logic [DW-1:0] input_tdata;
  logic          output_tvalid;
  logic          output_tready;
  logic [DW-1:0] output_tdata;

  int n_cmp;
  int n_err;
  int n_beats;
  logic [DW-1:0] q[$];

  skidbuffer #(.DW(DW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .input_tdata   (input_tdata),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready),
    .output_tdata  (output_tdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare DUT outputs with the queue model.
  task automatic check_model(input string tag);
    chk({tag, "_valid"}, output_tvalid, (q.size() > 0));
    chk({tag, "_ready"}, input_tready, (q.size() < 2));
    if (q.size() > 0) chk({tag, "_data"}, output_tdata, q[0]);
`ifdef SKIDBUFFER_DATA_CLEAR_EN
    else chk({tag, "_zero"}, output_tdata, 0);
`endif
  endtask

  // One clock: check current outputs, drive inputs, advance model at the edge.
  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic r, output logic acc);
    logic m_in, m_out;
    logic [DW-1:0] popped;
    check_model(tag);
    input_tvalid  = v;
    input_tdata   = d;
    output_tready = r;
    m_in  = v && (q.size() < 2);
    m_out = r && (q.size() > 0);
    acc   = m_in;
    @(posedge clock);
    if (m_out) begin
      popped = q.pop_front();
      n_beats++;
      $display("%s: beat %0d out data %02h", tag, n_beats, popped);
    end
    if (m_in) q.push_back(d);
    @(negedge clock);
  endtask

  initial begin
    logic acc;
    logic [DW-1:0] nxt;
    n_cmp = 0; n_err = 0; n_beats = 0;
    input_tvalid = 1'b1; input_tdata = 8'h5A; output_tready = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", output_tvalid, 0);
    chk("rst_ready", input_tready, 0);
    repeat (3) @(negedge clock);
    chk("rst_hold_valid", output_tvalid, 0);
    chk("rst_hold_ready", input_tready, 0);
    input_tvalid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rel_ready", input_tready, 1);
    chk("rel_valid", output_tvalid, 0);
`ifdef SKIDBUFFER_DATA_CLEAR_EN
    chk("rel_data_zero", output_tdata, 0);
`endif

    // Streaming: 0x01..0x10 back-to-back with the sink always ready.
    for (int i = 1; i <= 16; i++) begin
      cycle("stream", 1'b1, DW'(i), 1'b1, acc);
      chk("stream_acc", acc, 1);
      chk("stream_rdy", input_tready, 1);
      chk("stream_lat", output_tdata, i);
    end
    cycle("stream_drain", 1'b0, 8'h00, 1'b1, acc);
    chk("stream_end_valid", output_tvalid, 0);

    // Stall: sink blocked, three beats offered.
    cycle("stall", 1'b1, 8'hA1, 1'b0, acc);
    chk("stall_acc1", acc, 1);
    cycle("stall", 1'b1, 8'hA2, 1'b0, acc);
    chk("stall_acc2", acc, 1);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1'b1, 8'hA3, 1'b0, acc);
      chk("stall_acc3", acc, 0);
      chk("stall_rdy", input_tready, 0);
      chk("stall_hold", output_tdata, 8'hA1);
    end
    // FULL: one output transfer promotes the skid beat and reopens ready.
    cycle("full_pop", 1'b1, 8'hA3, 1'b1, acc);
    chk("full_pop_acc", acc, 0);
    chk("full_pop_data", output_tdata, 8'hA2);
    chk("full_pop_rdy", input_tready, 1);
    // BUSY with both transfers: stays BUSY holding the new beat.
    cycle("busy_both", 1'b1, 8'hA3, 1'b1, acc);
    chk("busy_both_acc", acc, 1);
    chk("busy_both_data", output_tdata, 8'hA3);
    chk("busy_both_valid", output_tvalid, 1);
    chk("busy_both_rdy", input_tready, 1);
    cycle("busy_drain", 1'b0, 8'h00, 1'b1, acc);
    chk("busy_drain_valid", output_tvalid, 0);

    // Random traffic at 50% on both sides; data advances only when accepted.
    nxt = 8'($urandom);
    for (int i = 0; i < 10000; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), nxt, 1'($urandom_range(0, 1)), acc);
      if (acc) nxt = 8'($urandom);
    end

    // Mid-stream reset from FULL, asserted between clock edges.
    while (q.size() > 0) cycle("pre_rst_drain", 1'b0, 8'h00, 1'b1, acc);
    cycle("fill", 1'b1, 8'hC1, 1'b0, acc);
    cycle("fill", 1'b1, 8'hC2, 1'b0, acc);
    chk("fill_full_rdy", input_tready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", output_tvalid, 0);
    chk("mid_rst_ready", input_tready, 0);
    q.delete();
    @(negedge clock);
    output_tready = 1'b1;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) cycle("post_rst", 1'b0, 8'h00, 1'b1, acc);
    for (int i = 0; i < 200; i++) begin
      cycle("post_rand", 1'($urandom_range(0, 1)), nxt, 1'($urandom_range(0, 1)), acc);
      if (acc) nxt = 8'($urandom);
    end
    while (q.size() > 0) cycle("final_drain", 1'b0, 8'h00, 1'b1, acc);
    check_model("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
